// File: rtl/adder_rr_arbiter.sv
// rtl/adder_rr_arbiter.sv - round-robin arbitrated shared registered adder
// One W-bit adder shared by NREQ valid/ready requesters; one-deep tagged result register.

module adder_rr_arbiter #(
  parameter  int NREQ = 4,
  parameter  int W    = 6,
  parameter  int DIV  = 1,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W:0]        res_sum,
  output logic [IDW-1:0]    res_id,
  output logic [7:0]        op_count
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           res_valid_q, res_valid_d;
  logic [W:0]     res_sum_q, res_sum_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic [7:0]     op_count_q, op_count_d;

  logic           tick;
  logic           pop;
  logic           can_issue;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic           transfer;
  logic [W-1:0]   sel_a, sel_b;

  // Free-running pacing counter; an unused tick is simply lost.
  assign tick  = (cnt_q == CW'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  assign pop       = res_valid_q & res_ready;
  assign can_issue = rst_n & tick & (~res_valid_q | res_ready);

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  assign transfer  = can_issue & grant_found;
  assign req_ready = transfer ? (NREQ'(1) << grant_idx) : '0;

  assign sel_a = req_a[int'(grant_idx)*W +: W];
  assign sel_b = req_b[int'(grant_idx)*W +: W];

  always_comb begin
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
    op_count_d  = op_count_q;
    if (pop) begin
      res_valid_d = 1'b0;
      op_count_d  = op_count_q + 8'd1;
    end
    // A load in the same cycle as a pop keeps the register full.
    if (transfer) begin
      res_valid_d = 1'b1;
      res_sum_d   = {1'b0, sel_a} + {1'b0, sel_b};
      res_id_d    = grant_idx;
      ptr_d       = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= '0;
      op_count_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
      op_count_q  <= op_count_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb/tb_adder_rr_arbiter.sv - directed vector bench for adder_rr_arbiter
// DIV=1 instance for function/backpressure/reset, DIV=3 instance for pacing.

module tb_adder_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [23:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        res_valid, res_ready;
  logic [6:0]  res_sum;
  logic [1:0]  res_id;
  logic [7:0]  op_count;

  logic [3:0]  p_valid;
  logic [23:0] p_a, p_b;
  logic [3:0]  p_ready;
  logic        p_res_valid, p_res_ready;
  logic [6:0]  p_sum;
  logic [1:0]  p_id;
  logic [7:0]  p_count;

  int errors = 0;
  int checks = 0;

  adder_rr_arbiter #(.NREQ(4), .W(6), .DIV(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_id(res_id), .op_count(op_count)
  );

  adder_rr_arbiter #(.NREQ(4), .W(6), .DIV(3)) u_pace (
    .clk(clk), .rst_n(rst_n), .req_valid(p_valid), .req_a(p_a), .req_b(p_b),
    .req_ready(p_ready), .res_valid(p_res_valid), .res_ready(p_res_ready),
    .res_sum(p_sum), .res_id(p_id), .op_count(p_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [23:0] a;
    logic [23:0] b;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_rv;
    logic [6:0]  exp_sum;
    logic [1:0]  exp_id;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[8];

  // Per-requester operands: a = {10,63,1,5}, b = {20,63,2,9}.
  localparam logic [23:0] A_OPS = {6'd10, 6'd63, 6'd1, 6'd5};
  localparam logic [23:0] B_OPS = {6'd20, 6'd63, 6'd2, 6'd9};
  logic [6:0] sums[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    sums[0] = 7'd14; sums[1] = 7'd3; sums[2] = 7'd126; sums[3] = 7'd30;

    vecs[0] = '{4'b0001, A_OPS, B_OPS, 1'b1, 4'b0001, 1'b1, 7'd14,  2'd0, 8'd0};
    vecs[1] = '{4'b0100, A_OPS, B_OPS, 1'b1, 4'b0100, 1'b1, 7'd126, 2'd2, 8'd1};
    vecs[2] = '{4'b0000, A_OPS, B_OPS, 1'b1, 4'b0000, 1'b0, 7'd126, 2'd2, 8'd2};
    vecs[3] = '{4'b1010, A_OPS, B_OPS, 1'b1, 4'b1000, 1'b1, 7'd30,  2'd3, 8'd2};
    vecs[4] = '{4'b1010, A_OPS, B_OPS, 1'b1, 4'b0010, 1'b1, 7'd3,   2'd1, 8'd3};
    vecs[5] = '{4'b1010, A_OPS, B_OPS, 1'b1, 4'b1000, 1'b1, 7'd30,  2'd3, 8'd4};
    vecs[6] = '{4'b0001, A_OPS, B_OPS, 1'b1, 4'b0001, 1'b1, 7'd14,  2'd0, 8'd5};
    vecs[7] = '{4'b0000, A_OPS, B_OPS, 1'b1, 4'b0000, 1'b0, 7'd14,  2'd0, 8'd6};

    rst_n = 1'b0; req_valid = '0; req_a = A_OPS; req_b = B_OPS; res_ready = 1'b0;
    p_valid = '0; p_a = A_OPS; p_b = B_OPS; p_res_ready = 1'b1;

    // Reset state, with all requesters valid
    @(negedge clk);
    req_valid = 4'hF; res_ready = 1'b1;
    #1 chk("reset_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    chk("reset_res_valid", 32'(res_valid), 32'h0);
    chk("reset_res_sum", 32'(res_sum), 32'h0);
    chk("reset_res_id", 32'(res_id), 32'h0);
    chk("reset_op_count", 32'(op_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = '0;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 8; i++) begin
      req_valid = vecs[i].valid; req_a = vecs[i].a; req_b = vecs[i].b; res_ready = vecs[i].rdy;
      #1 chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_res_valid", i), 32'(res_valid), 32'(vecs[i].exp_rv));
      chk($sformatf("vec%0d_res_sum", i), 32'(res_sum), 32'(vecs[i].exp_sum));
      chk($sformatf("vec%0d_res_id", i), 32'(res_id), 32'(vecs[i].exp_id));
      chk($sformatf("vec%0d_op_count", i), 32'(op_count), 32'(vecs[i].exp_cnt));
      @(negedge clk);
    end

    // Round-robin fairness: 8 results, order 0,1,2,3,0,1,2,3
    do_reset();
    req_valid = 4'hF; res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("rr%0d_req_ready", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
      @(posedge clk); #1;
      chk($sformatf("rr%0d_res_id", k), 32'(res_id), 32'(k % 4));
      chk($sformatf("rr%0d_res_sum", k), 32'(res_sum), 32'(sums[k % 4]));
      @(negedge clk);
    end
    req_valid = '0;
    @(posedge clk); #1;
    chk("rr_op_count", 32'(op_count), 32'd8);
    chk("rr_drain_valid", 32'(res_valid), 32'h0);
    @(negedge clk);

    // Backpressure: hold result 5 cycles, then pop and grant together
    req_valid = 4'b0001; res_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp_load_sum", 32'(res_sum), 32'd14);
    @(negedge clk);
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_res_valid", k), 32'(res_valid), 32'h1);
      chk($sformatf("bp%0d_res_sum", k), 32'(res_sum), 32'd14);
      chk($sformatf("bp%0d_op_count", k), 32'(op_count), 32'd8);
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1 chk("bp_release_req_ready", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    chk("bp_release_res_valid", 32'(res_valid), 32'h1);
    chk("bp_release_res_sum", 32'(res_sum), 32'd3);
    chk("bp_release_res_id", 32'(res_id), 32'd1);
    chk("bp_release_op_count", 32'(op_count), 32'd9);
    @(negedge clk);
    req_valid = '0;
    @(posedge clk); #1;
    chk("bp_drain_op_count", 32'(op_count), 32'd10);
    @(negedge clk);

    // Reset while a result is held
    req_valid = 4'b0100; res_ready = 1'b0;
    @(posedge clk); #1;
    chk("mid_held_res_id", 32'(res_id), 32'd2);
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'hF;
    #1 chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    chk("mid_rst_res_valid", 32'(res_valid), 32'h0);
    chk("mid_rst_op_count", 32'(op_count), 32'h0);
    chk("mid_rst_res_sum", 32'(res_sum), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; res_ready = 1'b1;
    #1 chk("mid_first_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    chk("mid_first_res_id", 32'(res_id), 32'd0);
    @(negedge clk);

    // op_count wrap 255 -> 0
    do_reset();
    req_valid = 4'hF; res_ready = 1'b1;
    repeat (256) @(posedge clk);
    #1 chk("wrap_op_count_255", 32'(op_count), 32'd255);
    @(posedge clk); #1;
    chk("wrap_op_count_0", 32'(op_count), 32'd0);
    @(negedge clk);
    req_valid = '0;

    // Pacing with DIV=3: grant only when cnt==2
    do_reset();
    p_valid = 4'b0001;
    for (int k = 0; k < 9; k++) begin
      #1 chk($sformatf("pace%0d_req_ready", k), 32'(p_ready), (k % 3 == 2) ? 32'h1 : 32'h0);
      @(posedge clk);
      @(negedge clk);
    end
    chk("pace_res_sum", 32'(p_sum), 32'd14);
    chk("pace_op_count", 32'(p_count), 32'd2);
    p_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
